// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternating grant on contention).
package arbiter_types;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_SIDE_I = 1'b0,
        ARB_SIDE_D = 1'b1
    } arb_side_t;

    // Maps the winning side onto the FSM state that owns the memory port.
    function automatic arb_state_t grant_state(input arb_side_t side);
        arb_state_t st;
        case (side)
            ARB_SIDE_D: st = ARB_GRANT_D;
            ARB_SIDE_I: st = ARB_GRANT_I;
            default:    st = ARB_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-style request/response bus. The requester (or the arbiter toward
// memory) uses the master modport; the responder uses the slave modport.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mbe;
    logic [DATA_W-1:0] rdata;
    logic              resp;

    modport master (output read, write, addr, wdata, mbe, input rdata, resp);
    modport slave  (input read, write, addr, wdata, mbe, output rdata, resp);

endinterface

// File: rtl/mem_port_arbiter_arb_select.sv
// Combinational winner pick between the I and D requesters.
// ARB_ROUND_ROBIN_EN: contention goes to the side not granted last;
// otherwise D always beats I.
module arb_select
    import arbiter_types::*;
(
    input  logic      i_req_i,
    input  logic      d_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_side_t last_grant_i,
`endif
    output logic      grant_valid_o,
    output arb_side_t grant_side_o
);

    // Select the winning side from the current requests.
    always_comb begin
        grant_valid_o = i_req_i | d_req_i;
        grant_side_o  = ARB_SIDE_I;
        if (i_req_i && d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (last_grant_i == ARB_SIDE_I) begin
                grant_side_o = ARB_SIDE_D;
            end else begin
                grant_side_o = ARB_SIDE_I;
            end
`else
            grant_side_o = ARB_SIDE_D;
`endif
        end else if (d_req_i) begin
            grant_side_o = ARB_SIDE_D;
        end else begin
            grant_side_o = ARB_SIDE_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// Protocol checker for the arbiter: the winning requester must never raise
// read and write together (write would silently win).
module mem_port_arbiter_chk (
    input logic clk_i,
    input logic rst_i,
    input logic idle_i,
    input logic grant_valid_i,
    input logic rw_conflict_i
);

    a_no_rw_conflict: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(idle_i && grant_valid_i && rw_conflict_i)
    ) else $error("mem_port_arbiter: winner has read and write both high");

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-side and a data-side
// requester. The grant and the address/data/byte enables are registered for
// the whole transaction; the memory response is routed to the granted side.
// Optional build macro: ARB_ROUND_ROBIN_EN (adds a last_grant register).
module mem_port_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
)(
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  i_port,
    mem_port_arbiter_if.slave  d_port,
    mem_port_arbiter_if.master m_port,
    output logic [CNT_W-1:0]   contend_cnt_o
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_t        state_q,   state_d;
    logic              m_read_q,  m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [MASK_W-1:0] m_mbe_q,   m_mbe_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic              i_req_s;
    logic              d_req_s;
    logic              grant_valid_s;
    arb_side_t         grant_side_s;
    logic              win_read_s;
    logic              win_write_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;
    logic [MASK_W-1:0] win_mbe_s;
    logic              rw_conflict_s;
    logic              i_resp_s;
    logic              d_resp_s;
    logic              resp_ok_s;

    assign i_req_s       = i_port.read | i_port.write;
    assign d_req_s       = d_port.read | d_port.write;
    assign rw_conflict_s = win_read_s & win_write_s;
    // A response landing in the reset cycle belongs to an abandoned transaction.
    assign resp_ok_s     = m_port.resp & ~rst;

`ifdef ARB_ROUND_ROBIN_EN
    arb_side_t last_grant_q, last_grant_d;
`endif

    arb_select u_select (
        .i_req_i       (i_req_s),
        .d_req_i       (d_req_s),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant_i  (last_grant_q),
`endif
        .grant_valid_o (grant_valid_s),
        .grant_side_o  (grant_side_s)
    );

    // Steer the winning side's request fields toward the memory registers.
    always_comb begin
        win_read_s  = i_port.read;
        win_write_s = i_port.write;
        win_addr_s  = i_port.addr;
        win_wdata_s = i_port.wdata;
        win_mbe_s   = i_port.mbe;
        if (grant_side_s == ARB_SIDE_D) begin
            win_read_s  = d_port.read;
            win_write_s = d_port.write;
            win_addr_s  = d_port.addr;
            win_wdata_s = d_port.wdata;
            win_mbe_s   = d_port.mbe;
        end else begin
            win_read_s  = i_port.read;
            win_write_s = i_port.write;
            win_addr_s  = i_port.addr;
            win_wdata_s = i_port.wdata;
            win_mbe_s   = i_port.mbe;
        end
    end

    // Next-state, memory-register and response-pulse logic.
    always_comb begin
        state_d   = state_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_mbe_d   = m_mbe_q;
        cnt_d     = cnt_q;
        i_resp_s  = 1'b0;
        d_resp_s  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (i_req_s && d_req_s && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
                if (grant_valid_s) begin
                    // Write takes precedence when a side raises both strobes.
                    m_write_d = win_write_s;
                    m_read_d  = win_read_s & ~win_write_s;
                    m_addr_d  = win_addr_s;
                    m_wdata_d = win_wdata_s;
                    m_mbe_d   = win_mbe_s;
                    state_d   = grant_state(grant_side_s);
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant_side_s;
`endif
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT_I: begin
                if (resp_ok_s) begin
                    i_resp_s  = 1'b1;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = ARB_IDLE;
                end else begin
                    state_d   = ARB_GRANT_I;
                end
            end
            ARB_GRANT_D: begin
                if (resp_ok_s) begin
                    d_resp_s  = 1'b1;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = ARB_IDLE;
                end else begin
                    state_d   = ARB_GRANT_D;
                end
            end
            default: begin
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    // State and memory-side registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= {ADDR_W{1'b0}};
            m_wdata_q <= {DATA_W{1'b0}};
            m_mbe_q   <= {MASK_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_mbe_q   <= m_mbe_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the last granted side so contention alternates.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ARB_SIDE_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign m_port.read    = m_read_q;
    assign m_port.write   = m_write_q;
    assign m_port.addr    = m_addr_q;
    assign m_port.wdata   = m_wdata_q;
    assign m_port.mbe     = m_mbe_q;
    assign i_port.rdata   = m_port.rdata;
    assign d_port.rdata   = m_port.rdata;
    assign i_port.resp    = i_resp_s;
    assign d_port.resp    = d_resp_s;
    assign contend_cnt_o  = cnt_q;

    mem_port_arbiter_chk u_chk (
        .clk_i         (clk),
        .rst_i         (rst),
        .idle_i        (state_q == ARB_IDLE),
        .grant_valid_i (grant_valid_s),
        .rw_conflict_i (rw_conflict_s)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (default fixed-priority
// build). Each table row is one clock cycle: inputs are driven on the falling
// edge and outputs are compared 1 time unit later.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cnt;

    mem_port_arbiter_if i_bus ();
    mem_port_arbiter_if d_bus ();
    mem_port_arbiter_if m_bus ();

    mem_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_port        (i_bus),
        .d_port        (d_bus),
        .m_port        (m_bus),
        .contend_cnt_o (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir, iw;
        logic [31:0] ia, iwd;
        logic [3:0]  ib;
        logic        dr, dw;
        logic [31:0] da, dwd;
        logic [3:0]  db;
        logic        mresp;
        logic [31:0] mrd;
        logic        emr, emw;
        logic [31:0] ema, emwd;
        logic [3:0]  emb;
        logic        eir, edr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t  vt [0:63];
    string vn [0:63];
    int    nv;
    int    n_vec;
    int    n_bad;

    task automatic add(input string n, input logic r,
                       input logic ir, input logic iw, input logic [31:0] ia, input logic [31:0] iwd, input logic [3:0] ib,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] db,
                       input logic mresp, input logic [31:0] mrd,
                       input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emwd, input logic [3:0] emb,
                       input logic eir, input logic edr, input logic [15:0] ecnt);
        vt[nv] = '{rst: r, ir: ir, iw: iw, ia: ia, iwd: iwd, ib: ib,
                   dr: dr, dw: dw, da: da, dwd: dwd, db: db, mresp: mresp, mrd: mrd,
                   emr: emr, emw: emw, ema: ema, emwd: emwd, emb: emb,
                   eir: eir, edr: edr, ecnt: ecnt};
        vn[nv] = n;
        nv++;
    endtask

    task automatic drive(input vec_t v);
        rst         = v.rst;
        i_bus.read  = v.ir;  i_bus.write = v.iw;  i_bus.addr = v.ia;
        i_bus.wdata = v.iwd; i_bus.mbe   = v.ib;
        d_bus.read  = v.dr;  d_bus.write = v.dw;  d_bus.addr = v.da;
        d_bus.wdata = v.dwd; d_bus.mbe   = v.db;
        m_bus.resp  = v.mresp;
        m_bus.rdata = v.mrd;
    endtask

    task automatic check(input string n, input vec_t v);
        n_vec++;
        if (m_bus.read !== v.emr || m_bus.write !== v.emw || m_bus.addr !== v.ema ||
            m_bus.wdata !== v.emwd || m_bus.mbe !== v.emb || i_bus.resp !== v.eir ||
            d_bus.resp !== v.edr || cnt !== v.ecnt ||
            i_bus.rdata !== v.mrd || d_bus.rdata !== v.mrd) begin
            n_bad++;
            $display("FAIL %s: got rd=%b wr=%b addr=%h wdata=%h mbe=%h iresp=%b dresp=%b cnt=%0d irdata=%h drdata=%h; want rd=%b wr=%b addr=%h wdata=%h mbe=%h iresp=%b dresp=%b cnt=%0d rdata=%h",
                     n, m_bus.read, m_bus.write, m_bus.addr, m_bus.wdata, m_bus.mbe,
                     i_bus.resp, d_bus.resp, cnt, i_bus.rdata, d_bus.rdata,
                     v.emr, v.emw, v.ema, v.emwd, v.emb, v.eir, v.edr, v.ecnt, v.mrd);
        end
    endtask

    task automatic check_bit(input string n, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", n, got, want);
        end
    endtask

    initial begin
        vec_t idle_v;
        int   lat;

        nv = 0; n_vec = 0; n_bad = 0;

        // name rst | ir iw ia iwd ib | dr dw da dwd db | mresp mrd || mr mw ma mwd mb | iresp dresp cnt
        add("reset_state",   1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,16'd0);
        add("i_rd_req",      1'b0, 1'b1,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,16'd0);
        add("i_rd_t1",       1'b0, 1'b1,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b1,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,16'd0);
        add("i_rd_t2",       1'b0, 1'b1,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b1,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,16'd0);
        add("i_rd_resp",     1'b0, 1'b1,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hDEADBEEF,1'b1,1'b0,32'h60,32'h0,4'hF, 1'b1,1'b0,16'd0);
        add("i_rd_done",     1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,16'd0);
        add("d_wr_req",      1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h100,32'h12345678,4'h3, 1'b0,32'h0, 1'b0,1'b0,32'h60,32'h0,4'hF, 1'b0,1'b0,16'd0);
        add("d_wr_t1",       1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h100,32'h12345678,4'h3, 1'b0,32'h0, 1'b0,1'b1,32'h100,32'h12345678,4'h3, 1'b0,1'b0,16'd0);
        add("d_wr_hold",     1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h200,32'h87654321,4'hC, 1'b0,32'h0, 1'b0,1'b1,32'h100,32'h12345678,4'h3, 1'b0,1'b0,16'd0);
        add("d_wr_resp",     1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b1,32'h200,32'h87654321,4'hC, 1'b1,32'h0, 1'b0,1'b1,32'h100,32'h12345678,4'h3, 1'b0,1'b1,16'd0);
        add("d_wr_done",     1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h100,32'h12345678,4'h3, 1'b0,1'b0,16'd0);
        add("contend",       1'b0, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b1,1'b0,32'h90,32'h0,4'hF, 1'b0,32'h0,     1'b0,1'b0,32'h100,32'h12345678,4'h3, 1'b0,1'b0,16'd0);
        add("contend_d_t1",  1'b0, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b1,1'b0,32'h90,32'h0,4'hF, 1'b0,32'h0,     1'b1,1'b0,32'h90,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("contend_d_resp",1'b0, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b1,1'b0,32'h90,32'h0,4'hF, 1'b1,32'hA5A5A5A5, 1'b1,1'b0,32'h90,32'h0,4'hF, 1'b0,1'b1,16'd1);
        add("contend_i_wait",1'b0, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b0,1'b0,32'h90,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("contend_i_t1",  1'b0, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b1,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("contend_i_resp",1'b0, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h11223344, 1'b1,1'b0,32'h80,32'h0,4'hF, 1'b1,1'b0,16'd1);
        add("contend_done",  1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("stray_resp",    1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'hFFFF0000, 1'b0,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("i_req_hold",    1'b0, 1'b1,1'b0,32'h40,32'hCAFEF00D,4'h1, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0, 1'b0,1'b0,32'h80,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("i_addr_chg",    1'b0, 1'b0,1'b0,32'h44,32'h0,4'h2, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b1,1'b0,32'h40,32'hCAFEF00D,4'h1, 1'b0,1'b0,16'd1);
        add("i_addr_resp",   1'b0, 1'b0,1'b0,32'h48,32'h0,4'h4, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h0BADF00D, 1'b1,1'b0,32'h40,32'hCAFEF00D,4'h1, 1'b1,1'b0,16'd1);
        add("i_addr_done",   1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h40,32'hCAFEF00D,4'h1, 1'b0,1'b0,16'd1);
        add("i_wr_req",      1'b0, 1'b0,1'b1,32'h70,32'h55AA55AA,4'hC, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0, 1'b0,1'b0,32'h40,32'hCAFEF00D,4'h1, 1'b0,1'b0,16'd1);
        add("i_wr_t1",       1'b0, 1'b0,1'b1,32'h70,32'h55AA55AA,4'hC, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0, 1'b0,1'b1,32'h70,32'h55AA55AA,4'hC, 1'b0,1'b0,16'd1);
        add("i_wr_resp",     1'b0, 1'b0,1'b1,32'h70,32'h55AA55AA,4'hC, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h0, 1'b0,1'b1,32'h70,32'h55AA55AA,4'hC, 1'b1,1'b0,16'd1);
        add("i_wr_done",     1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h70,32'h55AA55AA,4'hC, 1'b0,1'b0,16'd1);
        add("d_rd_req",      1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h300,32'h0,4'hF, 1'b0,32'h0,     1'b0,1'b0,32'h70,32'h55AA55AA,4'hC, 1'b0,1'b0,16'd1);
        add("d_rd_t1",       1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h300,32'h0,4'hF, 1'b0,32'h0,     1'b1,1'b0,32'h300,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("d_rd_rst",      1'b1, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,1'b0,32'h300,32'h0,4'hF, 1'b1,32'h77777777, 1'b1,1'b0,32'h300,32'h0,4'hF, 1'b0,1'b0,16'd1);
        add("post_rst",      1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,16'd0);
        add("post_rst_stray",1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h0,        1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,16'd0);
        add("post_rst_req",  1'b0, 1'b1,1'b0,32'h20,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,16'd0);
        add("post_rst_grant",1'b0, 1'b1,1'b0,32'h20,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,       1'b1,1'b0,32'h20,32'h0,4'hF, 1'b0,1'b0,16'd0);
        add("post_rst_resp", 1'b0, 1'b1,1'b0,32'h20,32'h0,4'hF, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b1,32'h13579BDF, 1'b1,1'b0,32'h20,32'h0,4'hF, 1'b1,1'b0,16'd0);
        add("post_rst_done", 1'b0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,1'b0,32'h0,32'h0,4'h0, 1'b0,32'h0,        1'b0,1'b0,32'h20,32'h0,4'hF, 1'b0,1'b0,16'd0);

        // Unchecked reset preamble.
        idle_v     = vt[0];
        idle_v.rst = 1'b1;
        @(negedge clk);
        drive(idle_v);
        @(negedge clk);
        @(negedge clk);

        for (int k = 0; k < nv; k++) begin
            @(negedge clk);
            drive(vt[k]);
            #1;
            check(vn[k], vt[k]);
        end

        // Back-to-back: D holds its request and memory answers at once;
        // the port must alternate busy/idle with one idle cycle between.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d_bus.read = 1'b1;
            d_bus.addr = 32'h500;
            d_bus.mbe  = 4'hF;
            m_bus.resp = m_bus.read;
            #1;
            check_bit($sformatf("b2b_rd_c%0d", c), m_bus.read, (c % 2) == 1);
            check_bit($sformatf("b2b_resp_c%0d", c), d_bus.resp, (c % 2) == 1);
        end

        // Grant latency from an I request seen in IDLE, with a bounded wait.
        @(negedge clk);
        d_bus.read = 1'b0;
        m_bus.resp = 1'b0;
        i_bus.read = 1'b1;
        i_bus.addr = 32'h600;
        lat = 0;
        #1;
        while (m_bus.read !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
            #1;
        end
        n_vec++;
        if (lat != 1) begin
            n_bad++;
            $display("FAIL grant_latency: got %0d cycles want 1", lat);
        end
        check_bit("lat_no_dresp", d_bus.resp, 1'b0);
        @(negedge clk);
        m_bus.resp  = 1'b1;
        m_bus.rdata = 32'h0F0F0F0F;
        #1;
        check_bit("lat_iresp", i_bus.resp, 1'b1);
        n_vec++;
        if (i_bus.rdata !== 32'h0F0F0F0F || cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL lat_rdata_cnt: got rdata=%h cnt=%0d want rdata=0f0f0f0f cnt=0", i_bus.rdata, cnt);
        end
        @(negedge clk);
        i_bus.read = 1'b0;
        m_bus.resp = 1'b0;
        #1;
        check_bit("lat_done_rd", m_bus.read, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
